// File: rtl/pipeline_latch_chain_if.sv
// ---------------------------------------------------------------------------
// pipeline_latch_chain_if
//   Bundle of signals between the fetch/hazard side of the WISC core and the
//   inter-stage pipeline register chain.
//
//   master : fetch + hazard unit (drives in_data/in_valid, stall_vec, flush_vec)
//   slave  : pipeline_latch_chain (drives in_ready, stage views, counters)
//
//   in_data     fetch bundle            in_valid    in_data is a real instruction
//   in_ready    chain accepts in_data   stall_vec   per-stage stall request
//   flush_vec   per-stage squash        stage_data  flattened stage bundles
//   stage_valid valid bit per stage     out_data    oldest stage bundle
//   out_valid   oldest stage valid      retire_cnt  retired instructions
//   bubble_cnt  cycles with a stall-inserted bubble
// ---------------------------------------------------------------------------
interface pipeline_latch_chain_if #(
  parameter int WIDTH      = 64,
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 16
);
  logic [WIDTH-1:0]            in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_STAGES-1:0]       stall_vec;
  logic [NUM_STAGES-1:0]       flush_vec;
  logic [NUM_STAGES*WIDTH-1:0] stage_data;
  logic [NUM_STAGES-1:0]       stage_valid;
  logic [WIDTH-1:0]            out_data;
  logic                        out_valid;
  logic [CNT_W-1:0]            retire_cnt;
  logic [CNT_W-1:0]            bubble_cnt;

  modport master (
    output in_data, in_valid, stall_vec, flush_vec,
    input  in_ready, stage_data, stage_valid, out_data, out_valid,
           retire_cnt, bubble_cnt
  );

  modport slave (
    input  in_data, in_valid, stall_vec, flush_vec,
    output in_ready, stage_data, stage_valid, out_data, out_valid,
           retire_cnt, bubble_cnt
  );
endinterface

// File: rtl/pipeline_latch_chain.sv
// ---------------------------------------------------------------------------
// pipeline_latch_chain
//   Parametrised chain of inter-stage pipeline registers for the 16-bit WISC
//   core. Stage 0 is the youngest (IF/ID), stage NUM_STAGES-1 the oldest
//   (MEM/WB). Each stage carries an opaque WIDTH-bit bundle plus a valid bit.
//
//   A stall at stage i freezes stages 0..i; the first non-held stage above a
//   held one receives a bubble. A flush at stage i squashes stages 0..i and
//   the fetch input; a held stage inside the squash zone stays held but turns
//   invalid. Invalid slots always carry all-zero data.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    pipeline_latch_chain_if.slave (see interface header)
// ---------------------------------------------------------------------------
module pipeline_latch_chain #(
  parameter int WIDTH      = 64,
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_latch_chain_if.slave  bus
);

  localparam int LAST = NUM_STAGES - 1;

  logic [WIDTH-1:0]      data_q [NUM_STAGES];
  logic [WIDTH-1:0]      data_n [NUM_STAGES];
  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] valid_n;
  logic [NUM_STAGES-1:0] hold;
  logic [NUM_STAGES-1:0] kill;
  logic                  bubble_any;
  logic                  retire_fire;
  logic [CNT_W-1:0]      retire_q;
  logic [CNT_W-1:0]      bubble_q;

  // hold/kill are suffix-ORs: a request at stage k affects every younger stage.
  always_comb begin : suffix_or
    logic h_acc;
    logic k_acc;
    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    hold  = '0;
    kill  = '0;
    h_acc = 1'b0;
    k_acc = 1'b0;
    for (int j = LAST; j >= 0; j--) begin
      h_acc   = h_acc | bus.stall_vec[j];
      k_acc   = k_acc | bus.flush_vec[j];
      hold[j] = h_acc;
      kill[j] = k_acc;
    end
  end

  always_comb begin : next_state
    valid_n    = '0;
    bubble_any = 1'b0;
    for (int j = 0; j < NUM_STAGES; j++) data_n[j] = '0;

    // Stage 0: hold, or take the fetch bundle.
    if (hold[0]) begin
      valid_n[0] = valid_q[0] & ~kill[0];
      data_n[0]  = data_q[0];
    end else begin
      valid_n[0] = bus.in_valid & ~kill[0];
      data_n[0]  = bus.in_data;
    end

    // Older stages: hold, bubble behind a held younger stage, or advance.
    for (int j = 1; j < NUM_STAGES; j++) begin
      if (hold[j]) begin
        valid_n[j] = valid_q[j] & ~kill[j];
        data_n[j]  = data_q[j];
      end else if (hold[j-1]) begin
        valid_n[j] = 1'b0;
        bubble_any = 1'b1;
      end else begin
        valid_n[j] = valid_q[j-1] & ~kill[j-1];
        data_n[j]  = data_q[j-1];
      end
    end

    // Squashed and empty slots read as all-zero.
    for (int j = 0; j < NUM_STAGES; j++) begin
      if (!valid_n[j]) data_n[j] = '0;
    end
  end

  assign retire_fire = valid_q[LAST] & ~bus.stall_vec[LAST];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of its neighbour and the chain shifts
  // by exactly one stage per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the stage data array is reset too, not just the valid bits,
      // because empty slots must read all-zero right out of reset.
      for (int j = 0; j < NUM_STAGES; j++) data_q[j] <= '0;
      valid_q  <= '0;
      retire_q <= '0;
      bubble_q <= '0;
    end else begin
      for (int j = 0; j < NUM_STAGES; j++) data_q[j] <= data_n[j];
      valid_q <= valid_n;
      if (retire_fire) retire_q <= retire_q + CNT_W'(1);
      if (bubble_any)  bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  always_comb begin : flatten
    bus.stage_data = '0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      bus.stage_data[j*WIDTH +: WIDTH] = data_q[j];
    end
  end

  assign bus.in_ready    = ~hold[0];
  assign bus.stage_valid = valid_q;
  assign bus.out_data    = data_q[LAST];
  assign bus.out_valid   = valid_q[LAST];
  assign bus.retire_cnt  = retire_q;
  assign bus.bubble_cnt  = bubble_q;

endmodule

// File: tb/tb_pipeline_latch_chain.sv
// ---------------------------------------------------------------------------
// tb_pipeline_latch_chain
//   Self-checking bench for pipeline_latch_chain (4 stages, 64-bit bundles,
//   4-bit counters so the wrap case is reachable). Expected retirement order
//   is pushed to a scoreboard queue as instructions are driven and popped
//   when the oldest stage retires; directed checks cover stall, flush,
//   flush-plus-stall, counters, wrap and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_pipeline_latch_chain;

  localparam int WIDTH      = 64;
  localparam int NUM_STAGES = 4;
  localparam int CNT_W      = 4;

  logic clk;
  logic rst_n;

  pipeline_latch_chain_if #(
    .WIDTH(WIDTH), .NUM_STAGES(NUM_STAGES), .CNT_W(CNT_W)
  ) bus ();

  pipeline_latch_chain #(
    .WIDTH(WIDTH), .NUM_STAGES(NUM_STAGES), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] sb [$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [63:0] d,
                       input logic [3:0] st, input logic [3:0] fl);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.stall_vec = st;
    bus.flush_vec = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] stage(input int j);
    return bus.stage_data[j*WIDTH +: WIDTH];
  endfunction

  // Retirement monitor: sampled on the falling edge, so the stall seen here is
  // the one the next rising edge will use.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && !bus.stall_vec[NUM_STAGES-1]) begin
      check("sb_nonempty_on_retire", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) check("retire_order", bus.out_data, sb.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 64'd0, 4'b0000, 4'b0000);

    // Reset state, and in_ready following stall_vec while in reset.
    #12;
    check("rst_valid", 64'(bus.stage_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_retire", 64'(bus.retire_cnt), 64'd0);
    check("rst_bubble", 64'(bus.bubble_cnt), 64'd0);
    bus.stall_vec = 4'b0001;
    #1 check("rst_in_ready_stall", 64'(bus.in_ready), 64'd0);
    bus.stall_vec = 4'b0000;
    #1 check("rst_in_ready_free", 64'(bus.in_ready), 64'd1);
    #3 rst_n = 1'b1;
    step();

    // Stream 1..5 back to back.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 64'(i), 4'b0000, 4'b0000);
      sb.push_back(64'(i));
      step();
      if (i == 4) begin
        check("stream_first_out", bus.out_data, 64'd1);
        check("stream_first_valid", 64'(bus.out_valid), 64'd1);
      end
    end
    drive(1'b0, 64'd0, 4'b0000, 4'b0000);
    repeat (4) step();
    check("stream_retire", 64'(bus.retire_cnt), 64'd5);
    check("stream_bubble", 64'(bus.bubble_cnt), 64'd0);
    check("stream_empty", 64'(bus.stage_valid), 64'd0);

    // Stall at stage 2 for two cycles with 13 in the oldest stage.
    for (int v = 13; v >= 10; v--) begin
      drive(1'b1, 64'(v), 4'b0000, 4'b0000);
      sb.push_back(64'(v));
      step();
    end
    drive(1'b0, 64'd0, 4'b0100, 4'b0000);
    #1 check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    check("stall1_valid", 64'(bus.stage_valid), 64'b0111);
    check("stall1_s3_zero", stage(3), 64'd0);
    check("stall1_s2", stage(2), 64'd12);
    check("stall1_bubble", 64'(bus.bubble_cnt), 64'd1);
    check("stall1_retire", 64'(bus.retire_cnt), 64'd6);
    step();
    check("stall2_valid", 64'(bus.stage_valid), 64'b0111);
    check("stall2_s3_zero", stage(3), 64'd0);
    check("stall2_s0", stage(0), 64'd10);
    check("stall2_bubble", 64'(bus.bubble_cnt), 64'd2);
    drive(1'b0, 64'd0, 4'b0000, 4'b0000);
    step();
    check("stall_resume_out", bus.out_data, 64'd12);
    check("stall_resume_bubble", 64'(bus.bubble_cnt), 64'd2);
    repeat (3) step();
    check("stall_retire", 64'(bus.retire_cnt), 64'd9);
    check("stall_empty", 64'(bus.stage_valid), 64'd0);

    // Flush at stage 1 while fetch offers 24.
    for (int v = 23; v >= 20; v--) begin
      drive(1'b1, 64'(v), 4'b0000, 4'b0000);
      if (v >= 22) sb.push_back(64'(v));
      step();
    end
    drive(1'b1, 64'd24, 4'b0000, 4'b0010);
    step();
    check("flush_valid", 64'(bus.stage_valid), 64'b1000);
    check("flush_out", bus.out_data, 64'd22);
    for (int j = 0; j < 3; j++) check("flush_zero", stage(j), 64'd0);
    check("flush_retire", 64'(bus.retire_cnt), 64'd10);
    drive(1'b0, 64'd0, 4'b0000, 4'b0000);
    step();
    check("flush_drain_retire", 64'(bus.retire_cnt), 64'd11);
    check("flush_drain_empty", 64'(bus.stage_valid), 64'd0);

    // Flush and stall both at stage 0.
    for (int v = 33; v >= 30; v--) begin
      drive(1'b1, 64'(v), 4'b0000, 4'b0000);
      if (v >= 31) sb.push_back(64'(v));
      step();
    end
    drive(1'b0, 64'd0, 4'b0001, 4'b0001);
    step();
    check("fs_valid", 64'(bus.stage_valid), 64'b1100);
    check("fs_s0_zero", stage(0), 64'd0);
    check("fs_s1_bubble", stage(1), 64'd0);
    check("fs_s2", stage(2), 64'd31);
    check("fs_out", bus.out_data, 64'd32);
    check("fs_bubble", 64'(bus.bubble_cnt), 64'd3);
    check("fs_retire", 64'(bus.retire_cnt), 64'd12);
    drive(1'b0, 64'd0, 4'b0000, 4'b0000);
    repeat (2) step();
    check("fs_drain_retire", 64'(bus.retire_cnt), 64'd14);
    check("fs_drain_empty", 64'(bus.stage_valid), 64'd0);

    // Asynchronous reset between edges with every stage valid.
    for (int v = 40; v <= 43; v++) begin
      drive(1'b1, 64'(v), 4'b0000, 4'b0000);
      step();
    end
    drive(1'b0, 64'd0, 4'b0000, 4'b0000);
    check("pre_rst_full", 64'(bus.stage_valid), 64'b1111);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.stage_valid), 64'd0);
    check("mid_rst_out", bus.out_data, 64'd0);
    check("mid_rst_retire", 64'(bus.retire_cnt), 64'd0);
    check("mid_rst_bubble", 64'(bus.bubble_cnt), 64'd0);
    step();
    rst_n = 1'b1;
    drive(1'b1, 64'd7, 4'b0000, 4'b0000);
    sb.push_back(64'd7);
    step();
    drive(1'b1, 64'd8, 4'b0000, 4'b0000);
    sb.push_back(64'd8);
    step();
    drive(1'b0, 64'd0, 4'b0000, 4'b0000);
    repeat (2) step();
    check("post_rst_out", bus.out_data, 64'd7);
    repeat (3) step();
    check("post_rst_retire", 64'(bus.retire_cnt), 64'd2);

    // Counter wrap: 17 retirements on a 4-bit counter.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    check("wrap_start", 64'(bus.retire_cnt), 64'd0);
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 64'(100 + i), 4'b0000, 4'b0000);
      sb.push_back(64'(100 + i));
      step();
    end
    drive(1'b0, 64'd0, 4'b0000, 4'b0000);
    repeat (4) step();
    check("wrap_retire", 64'(bus.retire_cnt), 64'd1);
    check("wrap_bubble", 64'(bus.bubble_cnt), 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_latch_chain.md
Name: pipeline_latch_chain

Overview:
- Parametrised chain of inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB at default depth) for the 16-bit WISC core.
- Carries an opaque per-instruction bundle (PC, regs, control, data) with a valid bit per stage.
- Implements per-stage stall with bubble insertion, per-stage flush/squash, and retire/bubble performance counters.
- Replaces hand-written per-stage registers; the core's hazard unit drives the stall and flush vectors.

Parameters:
WIDTH, 64, bits per stage bundle
NUM_STAGES, 4, number of pipeline registers (min 2)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  WIDTH  bundle from fetch
in_valid  in  1  in_data holds a real instruction
in_ready  out  1  chain accepts in_data this cycle
stall_vec  in  NUM_STAGES  bit i: instruction in stage i cannot advance
flush_vec  in  NUM_STAGES  bit i: squash stages 0..i (younger instructions)
stage_data  out  NUM_STAGES*WIDTH  stage i occupies bits [i*WIDTH +: WIDTH]
stage_valid  out  NUM_STAGES  valid bit per stage
out_data  out  WIDTH  equals stage NUM_STAGES-1 data
out_valid  out  1  equals stage_valid[NUM_STAGES-1]
retire_cnt  out  CNT_W  count of retired instructions
bubble_cnt  out  CNT_W  count of bubbles inserted by stalls

Behaviour:
- Reset (async, rst_n=0): all stage data=0, stage_valid=0, retire_cnt=0, bubble_cnt=0. in_ready then follows stall_vec combinationally.
- Stage 0 is youngest; stage NUM_STAGES-1 is oldest.
- hold[j] = OR of stall_vec[k] for k>=j. A stall at stage i freezes stage i and all younger stages.
- kill[j] = OR of flush_vec[k] for k>=j. A flush at stage i squashes stages 0..i and the fetch input.
- Per-stage next state, one cycle latency, evaluated at each rising clk edge:
  - hold[j]=1: data held; valid_n = valid[j] & ~kill[j].
  - j=0 and hold[0]=0: load in_data; valid_n = in_valid & ~kill[0].
  - j>0, hold[j]=0, hold[j-1]=1: bubble; valid_n=0.
  - j>0, hold[j]=0, hold[j-1]=0: data_n = data[j-1]; valid_n = valid[j-1] & ~kill[j-1].
- Invariant: when valid_n=0, data_n=0. Bubbles and squashed slots always read all-zero.
- Flush beats stall: a held stage inside the kill zone stays held but goes invalid/zero.
- in_ready = ~hold[0] (combinational). Input is consumed only when in_ready=1. If in_valid=1 with in_ready=0, the upstream holds its data.
- Retire: out_valid & ~stall_vec[NUM_STAGES-1] increments retire_cnt. The instruction leaves the chain that edge.
- Bubble: increments bubble_cnt once per cycle in which any stage j>0 loads a bubble, regardless of how many stages do so.
- Counters wrap modulo 2^CNT_W. Both counters can increment in the same cycle.
- stall_vec and flush_vec are sampled only at clock edges; no combinational path from them to stage_data.
- Reset asserted mid-operation clears everything immediately. The first edge after release behaves as from the empty state.

Test Plan:
- Stream: in_valid=1, in_data=1,2,3,4,5 on consecutive cycles, no stall/flush -> out_data=1 on cycle 4 after first accept, then 2..5 back-to-back; retire_cnt=5; bubble_cnt=0.
- Stall: fill with 10,11,12,13; hold stall_vec=4'b0100 for 2 cycles -> stages 0..2 frozen; stage 3 gets valid=0, data=0 each cycle; in_ready=0; bubble_cnt=2; 13 retires once, then 12 resumes; no instruction lost or duplicated.
- Flush: stages hold 20,21,22,23; flush_vec=4'b0010 with in_valid=1, in_data=24 -> next cycle stage_valid=4'b1000 (22 advanced), stage 3 data=22, stages 0..2 zero; 24 dropped; 23 retired.
- Flush plus stall: stall_vec=4'b0001, flush_vec=4'b0001 -> stage 0 held but valid=0, data=0; stage 1 receives a bubble; older stages advance normally.
- Counter wrap: CNT_W=4, retire 17 instructions -> retire_cnt=1.
- Reset mid-stream: assert rst_n=0 asynchronously between edges with all stages valid -> stage_valid=0, counters=0 before the next edge; after release, stream 7,8 -> out_data=7 four cycles after acceptance.
